// File: rtl/wb_cmd_master_if.sv
// Interface bundle for wb_cmd_master.
// It holds the host command port, the host response port and the Wishbone classic bus.
// The master modport is the view the initiator takes of these signals.
// The slave modport is the view taken by whatever drives the host side and answers on the bus.
interface wb_cmd_master_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
  // Host command port (valid/ready)
  logic                    cmd_v_i;
  logic                    cmd_ready_o;
  logic                    cmd_we_i;
  logic [ADDR_WIDTH-1:0]   cmd_addr_i;
  logic [DATA_WIDTH-1:0]   cmd_data_i;
  logic [SELECT_WIDTH-1:0] cmd_sel_i;

  // Host response port (valid/yumi)
  logic                    resp_v_o;
  logic                    resp_yumi_i;
  logic [DATA_WIDTH-1:0]   resp_data_o;
  logic                    resp_err_o;

  // Wishbone classic bus
  logic [ADDR_WIDTH-1:0]   adr_o;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic                    cyc_o;
  logic                    stb_o;
  logic [SELECT_WIDTH-1:0] sel_o;
  logic                    we_o;
  logic                    ack_i;
  logic                    err_i;

  modport master (
    input  cmd_v_i, cmd_we_i, cmd_addr_i, cmd_data_i, cmd_sel_i,
    output cmd_ready_o,
    input  resp_yumi_i,
    output resp_v_o, resp_data_o, resp_err_o,
    output adr_o, dat_o, cyc_o, stb_o, sel_o, we_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    output cmd_v_i, cmd_we_i, cmd_addr_i, cmd_data_i, cmd_sel_i,
    input  cmd_ready_o,
    output resp_yumi_i,
    input  resp_v_o, resp_data_o, resp_err_o,
    input  adr_o, dat_o, cyc_o, stb_o, sel_o, we_o,
    output dat_i, ack_i, err_i
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator.
// It takes one read or write command from the host, runs one Wishbone cycle
// and hands back data and status on a valid/yumi port.
// A response timeout protects the host from a responder that never answers.
module wb_cmd_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  wb_cmd_master_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // The counter must be able to hold TIMEOUT_CYCLES. It is at least one bit wide.
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]              state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   adr_reg, adr_next;
  logic [DATA_WIDTH-1:0]   dat_reg, dat_next;
  logic [SELECT_WIDTH-1:0] sel_reg, sel_next;
  logic                    we_reg, we_next;
  logic [DATA_WIDTH-1:0]   resp_data_reg, resp_data_next;
  logic                    resp_err_reg, resp_err_next;
  logic [CNT_W-1:0]        count_reg, count_next;

  logic in_idle, in_bus, in_resp;

  assign in_idle = (state_reg == IDLE);
  assign in_bus  = (state_reg == BUS);
  assign in_resp = (state_reg == RESP);

  // The handshake outputs are decoded from the state register alone.
  // Because reset clears the state asynchronously, cyc_o and stb_o also drop asynchronously.
  assign bus.cmd_ready_o = in_idle;
  assign bus.cyc_o       = in_bus;
  assign bus.stb_o       = in_bus;
  assign bus.resp_v_o    = in_resp;
  assign bus.resp_data_o = resp_data_reg;
  assign bus.resp_err_o  = resp_err_reg;
  assign bus.adr_o       = adr_reg;
  assign bus.dat_o       = dat_reg;
  assign bus.sel_o       = sel_reg;
  assign bus.we_o        = we_reg;

  // Next-state logic.
  // ack_i and err_i are looked at only in BUS, so a stray termination in IDLE or RESP has no effect.
  always_comb begin
    state_next     = state_reg;
    adr_next       = adr_reg;
    dat_next       = dat_reg;
    sel_next       = sel_reg;
    we_next        = we_reg;
    resp_data_next = resp_data_reg;
    resp_err_next  = resp_err_reg;
    count_next     = count_reg;

    case (state_reg)
      IDLE: begin
        if (bus.cmd_v_i) begin
          adr_next   = bus.cmd_addr_i;
          dat_next   = bus.cmd_data_i;
          sel_next   = bus.cmd_sel_i;
          we_next    = bus.cmd_we_i;
          count_next = '0;
          state_next = BUS;
        end
      end

      BUS: begin
        // Saturate rather than wrap so a disabled timeout cannot alias.
        if (count_reg != CNT_MAX) begin
          count_next = count_reg + 1'b1;
        end
        if (bus.err_i) begin
          // An error wins over an ack that arrives in the same cycle.
          resp_data_next = '0;
          resp_err_next  = 1'b1;
          state_next     = RESP;
        end else if (bus.ack_i) begin
          resp_data_next = we_reg ? '0 : bus.dat_i;
          resp_err_next  = 1'b0;
          state_next     = RESP;
        end else if (TO_EN && (count_reg == TO_LAST)) begin
          // At this point stb_o has been high for TIMEOUT_CYCLES cycles without an answer.
          resp_data_next = '0;
          resp_err_next  = 1'b1;
          state_next     = RESP;
        end
      end

      RESP: begin
        if (bus.resp_yumi_i) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  // Reset throws away any command in flight and any response still pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      adr_reg       <= '0;
      dat_reg       <= '0;
      sel_reg       <= '0;
      we_reg        <= 1'b0;
      resp_data_reg <= '0;
      resp_err_reg  <= 1'b0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      adr_reg       <= adr_next;
      dat_reg       <= dat_next;
      sel_reg       <= sel_next;
      we_reg        <= we_next;
      resp_data_reg <= resp_data_next;
      resp_err_reg  <= resp_err_next;
      count_reg     <= count_next;
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master.
// The Wishbone side is a small RAM model that registers ack one cycle after it sees stb.
// It can also be switched to answer with err, with ack and err together, or not at all.
module tb_wb_cmd_master;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  wb_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW)) bus();

  wb_cmd_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Responder modes: 0 = ack, 1 = err, 2 = ack+err together, 3 = silent.
  int          mode = 0;
  logic        force_ack = 1'b0;
  logic        ack_r, err_r;
  logic [31:0] rdat;
  logic [31:0] mem [0:255];

  assign bus.ack_i = ack_r | force_ack;
  assign bus.err_i = err_r;
  assign bus.dat_i = rdat;

  // Responder model. It terminates each strobe once, one cycle after it first sees it.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      rdat  <= '0;
    end else begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      if (bus.cyc_o && bus.stb_o && !ack_r && !err_r) begin
        case (mode)
          0: begin
            ack_r <= 1'b1;
            if (bus.we_o) begin
              for (int b = 0; b < 4; b++)
                if (bus.sel_o[b]) mem[bus.adr_o[9:2]][8*b +: 8] <= bus.dat_o[8*b +: 8];
            end else begin
              rdat <= mem[bus.adr_o[9:2]];
            end
          end
          1: err_r <= 1'b1;
          2: begin ack_r <= 1'b1; err_r <= 1'b1; rdat <= 32'h5A5A5A5A; end
          default: ;
        endcase
      end
    end
  end

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents a command at the current time and returns just after the edge that accepts it.
  task automatic send_cmd(input logic we, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int n;
    bus.cmd_v_i    = 1'b1;
    bus.cmd_we_i   = we;
    bus.cmd_addr_i = a;
    bus.cmd_data_i = d;
    bus.cmd_sel_i  = s;
    n = 0;
    while (!bus.cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(bus.cmd_ready_o), 32'd1);
    @(posedge clk);
    #1 bus.cmd_v_i = 1'b0;
  endtask

  // Counts the cycles after acceptance until resp_v_o is seen, and the cycles with stb_o high.
  task automatic wait_resp(output int lat, output int stbn);
    lat = 0;
    stbn = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.stb_o) stbn++;
    end while (!bus.resp_v_o && lat < 50);
    if (!bus.resp_v_o) chk("resp_wait_timeout", 32'(bus.resp_v_o), 32'd1);
  endtask

  // Consumes the response at the next edge, then checks that the master is back in IDLE.
  task automatic consume(input string tag);
    bus.resp_yumi_i = 1'b1;
    @(posedge clk);
    #1 bus.resp_yumi_i = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(bus.cmd_ready_o), 32'd1);
    chk({tag, "_respv_after"}, 32'(bus.resp_v_o), 32'd0);
  endtask

  initial begin
    int lat, stbn;

    vecs[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 16'h0010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 16'h0020, 32'h11223344, 4'hF, 32'h0, 1'b0};
    vecs[3] = '{1'b1, 16'h0020, 32'hAABBCCDD, 4'h2, 32'h0, 1'b0};
    vecs[4] = '{1'b0, 16'h0020, 32'h0,        4'hF, 32'h1122CC44, 1'b0};
    vecs[5] = '{1'b1, 16'h0020, 32'h55667788, 4'h9, 32'h0, 1'b0};
    vecs[6] = '{1'b0, 16'h0020, 32'h0,        4'hF, 32'h5522CC88, 1'b0};
    vecs[7] = '{1'b0, 16'h0010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};

    bus.cmd_v_i = 1'b0; bus.cmd_we_i = 1'b0; bus.cmd_addr_i = '0;
    bus.cmd_data_i = '0; bus.cmd_sel_i = '0; bus.resp_yumi_i = 1'b0;

    // Output values while reset is held low.
    #12;
    chk("rst_cyc", 32'(bus.cyc_o), 32'd0);
    chk("rst_stb", 32'(bus.stb_o), 32'd0);
    chk("rst_we", 32'(bus.we_o), 32'd0);
    chk("rst_respv", 32'(bus.resp_v_o), 32'd0);
    chk("rst_resperr", 32'(bus.resp_err_o), 32'd0);
    chk("rst_adr", 32'(bus.adr_o), 32'd0);
    chk("rst_dat", bus.dat_o, 32'd0);
    chk("rst_sel", 32'(bus.sel_o), 32'd0);
    chk("rst_respdata", bus.resp_data_o, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.cmd_ready_o), 32'd1);

    // Table of directed transfers against the RAM model.
    mode = 0;
    for (int i = 0; i < 8; i++) begin
      send_cmd(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel);
      wait_resp(lat, stbn);
      $display("txn %0d we=%0d addr=0x%04h sel=0x%h -> data=0x%08h err=%0d lat=%0d stb=%0d",
               i, vecs[i].we, vecs[i].addr, vecs[i].sel, bus.resp_data_o, bus.resp_err_o, lat, stbn);
      chk($sformatf("v%0d_data", i), bus.resp_data_o, vecs[i].exp_data);
      chk($sformatf("v%0d_err", i), 32'(bus.resp_err_o), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("v%0d_stb_cycles", i), 32'(stbn), 32'd2);
      chk($sformatf("v%0d_cyc_in_resp", i), 32'(bus.cyc_o), 32'd0);
      chk($sformatf("v%0d_ready_in_resp", i), 32'(bus.cmd_ready_o), 32'd0);
      consume($sformatf("v%0d", i));
    end

    // Bus error on the second BUS cycle, then ack and err together.
    for (int m = 1; m <= 2; m++) begin
      mode = m;
      send_cmd(m == 1 ? 1'b1 : 1'b0, 16'h0040, 32'h12345678, 4'hF);
      wait_resp(lat, stbn);
      $display("txn err mode=%0d -> data=0x%08h err=%0d lat=%0d", m, bus.resp_data_o, bus.resp_err_o, lat);
      chk($sformatf("err%0d_err", m), 32'(bus.resp_err_o), 32'd1);
      chk($sformatf("err%0d_data", m), bus.resp_data_o, 32'd0);
      chk($sformatf("err%0d_latency", m), 32'(lat), 32'd3);
      chk($sformatf("err%0d_cyc_low", m), 32'(bus.cyc_o), 32'd0);
      consume($sformatf("err%0d", m));
    end

    // Timeout with a silent responder, then late acks in RESP and IDLE.
    mode = 3;
    send_cmd(1'b0, 16'h0050, 32'h0, 4'hF);
    wait_resp(lat, stbn);
    $display("txn timeout -> data=0x%08h err=%0d lat=%0d stb=%0d", bus.resp_data_o, bus.resp_err_o, lat, stbn);
    chk("to_stb_cycles", 32'(stbn), 32'd8);
    chk("to_latency", 32'(lat), 32'd9);
    chk("to_err", 32'(bus.resp_err_o), 32'd1);
    chk("to_data", bus.resp_data_o, 32'd0);
    force_ack = 1'b1;
    @(negedge clk) force_ack = 1'b0;
    chk("to_late_ack_respv", 32'(bus.resp_v_o), 32'd1);
    chk("to_late_ack_err", 32'(bus.resp_err_o), 32'd1);
    chk("to_late_ack_cyc", 32'(bus.cyc_o), 32'd0);
    consume("to");
    force_ack = 1'b1;
    @(negedge clk) force_ack = 1'b0;
    chk("idle_ack_respv", 32'(bus.resp_v_o), 32'd0);
    chk("idle_ack_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("idle_ack_cyc", 32'(bus.cyc_o), 32'd0);

    // Backpressure: the response is held while the next command waits.
    mode = 0;
    send_cmd(1'b0, 16'h0020, 32'h0, 4'hF);
    wait_resp(lat, stbn);
    bus.cmd_v_i = 1'b1; bus.cmd_we_i = 1'b1; bus.cmd_addr_i = 16'h0030;
    bus.cmd_data_i = 32'hCAFEF00D; bus.cmd_sel_i = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_respv", k), 32'(bus.resp_v_o), 32'd1);
      chk($sformatf("bp%0d_data", k), bus.resp_data_o, 32'h5522CC88);
      chk($sformatf("bp%0d_ready", k), 32'(bus.cmd_ready_o), 32'd0);
    end
    bus.resp_yumi_i = 1'b1;
    @(posedge clk);
    #1 bus.resp_yumi_i = 1'b0;
    @(negedge clk);
    chk("bp_ready_idle", 32'(bus.cmd_ready_o), 32'd1);
    @(posedge clk);
    #1 bus.cmd_v_i = 1'b0;
    wait_resp(lat, stbn);
    $display("txn backpressure write -> data=0x%08h err=%0d lat=%0d", bus.resp_data_o, bus.resp_err_o, lat);
    chk("bp_wr_latency", 32'(lat), 32'd3);
    chk("bp_wr_err", 32'(bus.resp_err_o), 32'd0);
    consume("bp_wr");
    send_cmd(1'b0, 16'h0030, 32'h0, 4'hF);
    wait_resp(lat, stbn);
    $display("txn readback 0x0030 -> data=0x%08h err=%0d", bus.resp_data_o, bus.resp_err_o);
    chk("bp_rd_data", bus.resp_data_o, 32'hCAFEF00D);
    consume("bp_rd");

    // Asynchronous reset while stb_o is high.
    mode = 3;
    send_cmd(1'b0, 16'h0010, 32'h0, 4'hF);
    @(negedge clk);
    chk("ar_stb_before", 32'(bus.stb_o), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_stb_async", 32'(bus.stb_o), 32'd0);
    chk("ar_cyc_async", 32'(bus.cyc_o), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    chk("ar_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("ar_respv", 32'(bus.resp_v_o), 32'd0);
    chk("ar_adr", 32'(bus.adr_o), 32'd0);
    mode = 0;
    send_cmd(1'b0, 16'h0010, 32'h0, 4'hF);
    wait_resp(lat, stbn);
    $display("txn after reset read 0x0010 -> data=0x%08h err=%0d lat=%0d", bus.resp_data_o, bus.resp_err_o, lat);
    chk("ar_rd_data", bus.resp_data_o, 32'hDEADBEEF);
    chk("ar_rd_err", 32'(bus.resp_err_o), 32'd0);
    chk("ar_rd_latency", 32'(lat), 32'd3);
    consume("ar_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
